// File: rtl/bus_serial_tx.sv
// Serializes a captured address and data word onto two LSB-first serial lines
// with a per-bit ready handshake; every output is a flop.
module bus_serial_tx #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ready,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  addr_valid,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_shift_q, addr_shift_d;
    logic [DATA_WIDTH-1:0]   data_shift_q, data_shift_d;
    logic                    tx_address_q, tx_address_d;
    logic                    tx_data_q, tx_data_d;
    logic                    addr_valid_q, addr_valid_d;
    logic                    data_valid_q, data_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   addr_sel;
    logic [DATA_WIDTH-1:0]   data_sel;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_shift_d = addr_shift_q;
        data_shift_d = data_shift_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_shift_d = address;
                    data_shift_d = data_in;
                    idx_d        = '0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (ready) begin
                    if (idx_q == ADDR_LAST) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (ready) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the flops present the
        // bit for the cycle the FSM is entering, keeping them input-isolated.
        addr_sel     = addr_shift_d >> idx_d;
        data_sel     = data_shift_d >> idx_d;
        addr_valid_d = (state_d == ADDR);
        data_valid_d = (state_d == DATA);
        tx_address_d = addr_valid_d & addr_sel[0];
        tx_data_d    = data_valid_d & data_sel[0];
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            addr_shift_q <= '0;
            data_shift_q <= '0;
            tx_address_q <= 1'b0;
            tx_data_q    <= 1'b0;
            addr_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_shift_q <= addr_shift_d;
            data_shift_q <= data_shift_d;
            tx_address_q <= tx_address_d;
            tx_data_q    <= tx_data_d;
            addr_valid_q <= addr_valid_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tx_address = tx_address_q;
    assign tx_data    = tx_data_q;
    assign addr_valid = addr_valid_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bus_serial_tx.sv
// Bench for bus_serial_tx: table of transfers with stalls and stray starts,
// plus reset-abort and back-to-back sequences; serial bits checked via queues.
module tb_bus_serial_tx;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, start, ready;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          tx_address, tx_data, addr_valid, data_valid, busy, done;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit q_addr[$];
    bit q_data[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stall_at;
        int            stall_len;
        int            ignore_at;
        int            exp_busy;
    } vec_t;

    bus_serial_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .address(address),
        .data_in(data_in), .ready(ready), .tx_address(tx_address),
        .tx_data(tx_data), .addr_valid(addr_valid), .data_valid(data_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < AW; i++) q_addr.push_back(a[i]);
        for (int i = 0; i < DW; i++) q_data.push_back(d[i]);
    endtask

    // Scoreboard: a bit is popped only on the cycle it is consumed (ready=1).
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_exclusive", {31'd0, addr_valid & data_valid}, 0);
            if (addr_valid) begin
                if (q_addr.size() == 0) chk("addr_extra_bit", 1, 0);
                else begin
                    chk("tx_address", {31'd0, tx_address}, {31'd0, q_addr[0]});
                    if (ready) void'(q_addr.pop_front());
                end
            end else chk("tx_address_idle", {31'd0, tx_address}, 0);
            if (data_valid) begin
                if (q_data.size() == 0) chk("data_extra_bit", 1, 0);
                else begin
                    chk("tx_data", {31'd0, tx_data}, {31'd0, q_data[0]});
                    if (ready) void'(q_data.pop_front());
                end
            end else chk("tx_data_idle", {31'd0, tx_data}, 0);
        end
    end

    task automatic run_transfer(input vec_t v);
        int b, stalled, busy_n, done_n, k;
        push_expected(v.addr, v.data);
        @(posedge clk); #1;
        start = 1'b1; address = v.addr; data_in = v.data; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b = 0; stalled = 0; busy_n = 0; done_n = 0; k = 0;
        while (k < 200 && done_n == 0) begin
            if (v.stall_at == b && stalled < v.stall_len) begin
                ready = 1'b0;
                stalled++;
            end else ready = 1'b1;
            if (k == v.ignore_at) begin
                start = 1'b1; address = '1; data_in = '1;
            end else if (k == v.ignore_at + 1) start = 1'b0;
            @(negedge clk);
            if (k == 0) chk("first_addr_valid", {31'd0, addr_valid}, 1);
            if (!ready) begin
                if (b < AW) chk("stall_addr_phase", {30'd0, addr_valid, data_valid}, 2);
                else        chk("stall_data_phase", {30'd0, addr_valid, data_valid}, 1);
            end
            if (busy) busy_n++;
            if (done) done_n++;
            if (ready && (addr_valid || data_valid)) b++;
            k++;
            if (done_n == 0) begin
                @(posedge clk); #1;
            end
        end
        chk("done_seen", done_n, 1);
        chk("busy_cycles", busy_n, v.exp_busy);
        chk("bits_consumed", b, AW + DW);
        repeat (3) begin
            @(negedge clk);
            chk("post_done_idle", {30'd0, busy, done}, 0);
        end
        chk("queues_drained", q_addr.size() + q_data.size(), 0);
        start = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int cnt, seen;
        vecs[0] = '{12'hA5C, 8'h3B, -1, 0, -1, 21};
        vecs[1] = '{12'h123, 8'hC4,  5, 3, -1, 24};
        vecs[2] = '{12'h7FF, 8'h80, 11, 2, -1, 23};
        vecs[3] = '{12'h0F0, 8'h5A, -1, 0,  6, 21};
        vecs[4] = '{12'h000, 8'hFF, 15, 1, -1, 22};
        vecs[5] = '{12'hFFF, 8'h00, -1, 0, -1, 21};

        reset = 1'b1; start = 1'b1; ready = 1'b1; address = '1; data_in = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, tx_address, tx_data, addr_valid, data_valid, busy, done}, 0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) run_transfer(vecs[i]);

        // Reset while data bit 3 is on the line.
        push_expected(12'h9A6, 8'h71);
        @(posedge clk); #1;
        start = 1'b1; address = 12'h9A6; data_in = 8'h71; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (AW + 3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_reset_data_bit3", {30'd0, data_valid, tx_data}, 2'b10);
        @(posedge clk); #1;
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {26'd0, tx_address, tx_data, addr_valid, data_valid, busy, done}, 0);
        q_addr.delete();
        q_data.delete();
        mon_en = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        run_transfer('{12'h9A6, 8'h71, -1, 0, -1, 21});

        // Back-to-back with start held high.
        push_expected(12'h35A, 8'hE1);
        push_expected(12'h35A, 8'hE1);
        @(posedge clk); #1;
        start = 1'b1; address = 12'h35A; data_in = 8'hE1; ready = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < 100);
        chk("b2b_first_done", {31'd0, done}, 1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!addr_valid && cnt < 10);
        chk("b2b_gap", cnt, 2);
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < 100);
        chk("b2b_second_done", {31'd0, done}, 1);
        @(negedge clk);
        chk("b2b_idle", {30'd0, busy, done}, 0);
        chk("b2b_queues_drained", q_addr.size() + q_data.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
